alu_mem_sequencer: RTL

Command sequencer that drives the ALU through its memory-mapped register file. It accepts one ALU command (A, B, opcode) per handshake and writes the operands and opcode into mem registers 0–2. It then pulses the execute register (3), waits a fixed ALU latency, captures the ALU result and returns it on a response handshake. It sits between a command source (testbench or host) and the mem write port, and replaces direct register pokes in the top level.

---
 rtl/alu_mem_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/alu_mem_sequencer.sv
// Runs one ALU command through the memory-mapped register file: writes A, B and
// the opcode, pulses EXEC, waits the fixed ALU latency and returns the result.
module alu_mem_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int ALU_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [DATA_WIDTH-1:0]   cmd_a,
    input  logic [DATA_WIDTH-1:0]   cmd_b,
    input  logic [2:0]              cmd_op,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [2*DATA_WIDTH-1:0] alu_res,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2*DATA_WIDTH-1:0] rsp_res,
    output logic [2:0]              rsp_op,
    output logic                    busy
);

    if (ALU_LATENCY < 1 || ALU_LATENCY > 15 || DATA_WIDTH < 3 || ADDR_WIDTH < 2) begin : g_bad_config
        $error("alu_mem_sequencer: ALU_LATENCY must be 1..15, DATA_WIDTH >= 3, ADDR_WIDTH >= 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_A,
        ST_WR_B,
        ST_WR_OP,
        ST_WR_EXEC,
        ST_WAIT,
        ST_CLR_EXEC,
        ST_RESP
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic [2:0]              op_q;
    logic [3:0]              wait_cnt;
    logic                    we_nx;
    logic [ADDR_WIDTH-1:0]   addr_nx;
    logic [DATA_WIDTH-1:0]   wdata_nx;

    assign cmd_ready = (state == ST_IDLE) && reset;
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

    // The mem port is registered, so the write belonging to each state is decoded on entry to it.
    always_comb begin
        state_nx = state;
        we_nx    = 1'b0;
        addr_nx  = '0;
        wdata_nx = '0;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_nx = ST_WR_A;
                    we_nx    = 1'b1;
                    addr_nx  = ADDR_WIDTH'(0);
                    wdata_nx = cmd_a;
                end
            end
            ST_WR_A: begin
                state_nx = ST_WR_B;
                we_nx    = 1'b1;
                addr_nx  = ADDR_WIDTH'(1);
                wdata_nx = b_q;
            end
            ST_WR_B: begin
                state_nx = ST_WR_OP;
                we_nx    = 1'b1;
                addr_nx  = ADDR_WIDTH'(2);
                wdata_nx = DATA_WIDTH'(op_q);
            end
            ST_WR_OP: begin
                state_nx = ST_WR_EXEC;
                we_nx    = 1'b1;
                addr_nx  = ADDR_WIDTH'(3);
                wdata_nx = DATA_WIDTH'(1);
            end
            ST_WR_EXEC: begin
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nx = ST_CLR_EXEC;
                    we_nx    = 1'b1;
                    addr_nx  = ADDR_WIDTH'(3);
                    wdata_nx = '0;
                end
            end
            ST_CLR_EXEC: begin
                state_nx = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nx;
            mem_we    <= we_nx;
            mem_addr  <= addr_nx;
            mem_wdata <= wdata_nx;
        end
    end

    // Command latch, latency countdown and result capture; cmd_* only matter in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            wait_cnt <= '0;
            rsp_res  <= '0;
            rsp_op   <= '0;
        end else begin
            if (state == ST_IDLE && cmd_valid) begin
                a_q  <= cmd_a;
                b_q  <= cmd_b;
                op_q <= cmd_op;
            end
            if (state == ST_WR_EXEC) begin
                wait_cnt <= 4'(ALU_LATENCY - 1);
            end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state == ST_WAIT && wait_cnt == 4'd0) begin
                rsp_res <= alu_res;
                rsp_op  <= op_q;
            end
        end
    end

endmodule
